// File: rtl/rggen_maskable_access_initiator.sv
// rggen_maskable_access_initiator: rggen register-bus initiator for maskable registers, writes packed as {mask, data}.
// Optional request timeout enabled by defining RGGEN_MASKABLE_ACCESS_TIMEOUT_EN.
`ifndef RGGEN_READ
`define RGGEN_READ 2'b10
`endif
`ifndef RGGEN_WRITE
`define RGGEN_WRITE 2'b11
`endif
`ifndef RGGEN_OKAY
`define RGGEN_OKAY 2'b00
`endif
`ifndef RGGEN_SLAVE_ERROR
`define RGGEN_SLAVE_ERROR 2'b10
`endif
module rggen_maskable_access_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_command_valid,
  output logic                     o_command_ready,
  input  logic                     i_command_write,
  input  logic [ADDRESS_WIDTH-1:0] i_command_address,
  input  logic [BUS_WIDTH/2-1:0]   i_command_data,
  input  logic [BUS_WIDTH/2-1:0]   i_command_mask,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic [1:0]               o_response_status,
  output logic [BUS_WIDTH/2-1:0]   o_response_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH-1:0]     o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);
  localparam int HALF_WIDTH = BUS_WIDTH / 2;
  typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE} state_t;
  state_t                   state_q, state_d;
  logic                     register_valid_q, register_valid_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [BUS_WIDTH-1:0]     strobe_q, strobe_d;
  logic                     response_valid_q, response_valid_d;
  logic [1:0]               status_q, status_d;
  logic [HALF_WIDTH-1:0]    data_q, data_d;
  logic                     timeout;
  logic                     unused_read_data;
  assign unused_read_data = ^i_register_read_data[BUS_WIDTH-1:HALF_WIDTH];
`ifdef RGGEN_MASKABLE_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] count_q, count_d;
  // Count is held at zero outside REQUEST, so it is already clear on entry.
  assign count_d = (state_q == REQUEST) ? count_q + CW'(1) : '0;
  assign timeout = count_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk) count_q <= i_rst ? '0 : count_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  assign o_command_ready       = state_q == IDLE;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;
  assign o_response_valid      = response_valid_q;
  assign o_response_status     = status_q;
  assign o_response_data       = data_q;
  always_comb begin
    state_d          = state_q;
    register_valid_d = register_valid_q;
    access_d         = access_q;
    address_d        = address_q;
    write_data_d     = write_data_q;
    strobe_d         = strobe_q;
    response_valid_d = response_valid_q;
    status_d         = status_q;
    data_d           = data_q;
    case (state_q)
      IDLE: if (i_command_valid) begin
        state_d          = REQUEST;
        register_valid_d = 1'b1;
        access_d         = i_command_write ? `RGGEN_WRITE : `RGGEN_READ;
        address_d        = i_command_address;
        write_data_d     = i_command_write ? {i_command_mask, i_command_data} : '0;
        strobe_d         = i_command_write ? '1 : '0;
      end
      REQUEST: if (i_register_ready || timeout) begin
        state_d          = RESPONSE;
        register_valid_d = 1'b0;
        response_valid_d = 1'b1;
        status_d         = i_register_ready ? i_register_status : `RGGEN_SLAVE_ERROR;
        data_d           = (i_register_ready && access_q == `RGGEN_READ) ? i_register_read_data[HALF_WIDTH-1:0] : '0;
      end
      RESPONSE: if (i_response_ready) begin
        state_d          = IDLE;
        response_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= IDLE;
      register_valid_q <= 1'b0;
      access_q         <= '0;
      address_q        <= '0;
      write_data_q     <= '0;
      strobe_q         <= '0;
      response_valid_q <= 1'b0;
      status_q         <= '0;
      data_q           <= '0;
    end else begin
      state_q          <= state_d;
      register_valid_q <= register_valid_d;
      access_q         <= access_d;
      address_q        <= address_d;
      write_data_q     <= write_data_d;
      strobe_q         <= strobe_d;
      response_valid_q <= response_valid_d;
      status_q         <= status_d;
      data_q           <= data_d;
    end
  end
endmodule

// File: tb/tb_rggen_maskable_access_initiator.sv
// tb_rggen_maskable_access_initiator: scoreboard bench; expected requests/responses queued by stimulus, checked by a monitor.
`ifndef RGGEN_READ
`define RGGEN_READ 2'b10
`endif
`ifndef RGGEN_WRITE
`define RGGEN_WRITE 2'b11
`endif
`ifndef RGGEN_OKAY
`define RGGEN_OKAY 2'b00
`endif
`ifndef RGGEN_SLAVE_ERROR
`define RGGEN_SLAVE_ERROR 2'b10
`endif
module tb_rggen_maskable_access_initiator;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_command_valid = 1'b0, o_command_ready, i_command_write = 1'b0;
  logic [7:0]  i_command_address = '0;
  logic [15:0] i_command_data = '0, i_command_mask = '0;
  logic        o_response_valid, i_response_ready = 1'b0;
  logic [1:0]  o_response_status;
  logic [15:0] o_response_data;
  logic        o_register_valid;
  logic [1:0]  o_register_access;
  logic [7:0]  o_register_address;
  logic [31:0] o_register_write_data, o_register_strobe;
  logic        i_register_ready = 1'b0;
  logic [1:0]  i_register_status = '0;
  logic [31:0] i_register_read_data = '0;
  always #5 clk = ~clk;
  rggen_maskable_access_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_command_valid(i_command_valid), .o_command_ready(o_command_ready),
    .i_command_write(i_command_write), .i_command_address(i_command_address),
    .i_command_data(i_command_data), .i_command_mask(i_command_mask),
    .o_response_valid(o_response_valid), .i_response_ready(i_response_ready),
    .o_response_status(o_response_status), .o_response_data(o_response_data),
    .o_register_valid(o_register_valid), .o_register_access(o_register_access),
    .o_register_address(o_register_address), .o_register_write_data(o_register_write_data),
    .o_register_strobe(o_register_strobe), .i_register_ready(i_register_ready),
    .i_register_status(i_register_status), .i_register_read_data(i_register_read_data)
  );
  typedef struct packed {logic [1:0] acc; logic [7:0] addr; logic [31:0] wd; logic [31:0] st;} req_t;
  typedef struct packed {logic [1:0] status; logic [15:0] data;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask
  // Compares every cycle an output is valid, so held-stable behaviour is checked too.
  always @(negedge clk) if (!i_rst) begin
    if (o_register_valid) begin
      if (req_q.size() == 0) check("spurious_request", 32'd1, 32'd0);
      else begin
        check("req_access", {30'd0, o_register_access}, {30'd0, req_q[0].acc});
        check("req_address", {24'd0, o_register_address}, {24'd0, req_q[0].addr});
        check("req_write_data", o_register_write_data, req_q[0].wd);
        check("req_strobe", o_register_strobe, req_q[0].st);
        if (i_register_ready) void'(req_q.pop_front());
      end
    end
    if (o_response_valid) begin
      if (rsp_q.size() == 0) check("spurious_response", 32'd1, 32'd0);
      else begin
        check("rsp_status", {30'd0, o_response_status}, {30'd0, rsp_q[0].status});
        check("rsp_data", {16'd0, o_response_data}, {16'd0, rsp_q[0].data});
        if (i_response_ready) void'(rsp_q.pop_front());
      end
    end
  end
  task automatic run(input logic wr, input logic [7:0] addr, input logic [15:0] data, input logic [15:0] mask,
                     input int tdelay, input logic [31:0] rdata, input logic [1:0] tstatus, input int rdelay, input bit tmo);
    req_t r;
    rsp_t s;
    r.acc = wr ? `RGGEN_WRITE : `RGGEN_READ;
    r.addr = addr;
    r.wd = wr ? {mask, data} : 32'd0;
    r.st = wr ? 32'hFFFF_FFFF : 32'd0;
    s.status = tmo ? `RGGEN_SLAVE_ERROR : tstatus;
    s.data = (wr || tmo) ? 16'd0 : rdata[15:0];
    req_q.push_back(r);
    rsp_q.push_back(s);
    check("cmd_ready_idle", {31'd0, o_command_ready}, 32'd1);
    i_command_valid = 1'b1; i_command_write = wr; i_command_address = addr;
    i_command_data = data; i_command_mask = mask;
    @(posedge clk); #1;
    i_command_valid = 1'b0;
    check("cmd_ready_busy", {31'd0, o_command_ready}, 32'd0);
    check("reg_valid_rise", {31'd0, o_register_valid}, 32'd1);
    if (tmo) begin
      repeat (4) @(posedge clk);
      #1;
      void'(req_q.pop_front());
    end else begin
      repeat (tdelay) begin @(posedge clk); #1; end
      i_register_ready = 1'b1; i_register_status = tstatus; i_register_read_data = rdata;
      @(posedge clk); #1;
      i_register_ready = 1'b0; i_register_status = 2'b11; i_register_read_data = 32'h5A5A_5A5A;
    end
    check("reg_valid_drop", {31'd0, o_register_valid}, 32'd0);
    check("rsp_valid_rise", {31'd0, o_response_valid}, 32'd1);
    for (int i = 0; i < rdelay; i++) begin
      i_command_valid = 1'b1; i_command_write = 1'b1; i_command_address = 8'hEE;
      check("cmd_ready_hold", {31'd0, o_command_ready}, 32'd0);
      @(posedge clk); #1;
    end
    i_response_ready = 1'b1;
    check("cmd_ready_hs", {31'd0, o_command_ready}, 32'd0);
    @(posedge clk); #1;
    i_response_ready = 1'b0; i_command_valid = 1'b0;
    check("rsp_valid_drop", {31'd0, o_response_valid}, 32'd0);
    check("cmd_ready_after", {31'd0, o_command_ready}, 32'd1);
    check("no_early_accept", {31'd0, o_register_valid}, 32'd0);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_reg_valid"}, {31'd0, o_register_valid}, 32'd0);
    check({tag, "_access"}, {30'd0, o_register_access}, 32'd0);
    check({tag, "_address"}, {24'd0, o_register_address}, 32'd0);
    check({tag, "_wdata"}, o_register_write_data, 32'd0);
    check({tag, "_strobe"}, o_register_strobe, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, o_response_valid}, 32'd0);
    check({tag, "_rsp_status"}, {30'd0, o_response_status}, 32'd0);
    check({tag, "_rsp_data"}, {16'd0, o_response_data}, 32'd0);
    check({tag, "_cmd_ready"}, {31'd0, o_command_ready}, 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_post_reset", {31'd0, o_command_ready}, 32'd1);
    run(1'b1, 8'h10, 16'h00A5, 16'h00FF, 3, 32'h0, `RGGEN_OKAY, 0, 1'b0);
    run(1'b0, 8'h14, 16'h0, 16'h0, 0, 32'hDEAD_1234, `RGGEN_OKAY, 0, 1'b0);
    run(1'b1, 8'h20, 16'h1234, 16'hF0F0, 1, 32'h0, `RGGEN_OKAY, 5, 1'b0);
    run(1'b0, 8'h24, 16'h0, 16'h0, 2, 32'hCAFE_BABE, `RGGEN_OKAY, 0, 1'b0);
    run(1'b1, 8'h30, 16'h5555, 16'h0000, 2, 32'h0, `RGGEN_SLAVE_ERROR, 1, 1'b0);
    run(1'b0, 8'h34, 16'h0, 16'h0, 1, 32'h8765_ABCD, 2'b01, 0, 1'b0);
    i_command_valid = 1'b1; i_command_write = 1'b1; i_command_address = 8'h50;
    i_command_data = 16'h7777; i_command_mask = 16'hFFFF;
    @(posedge clk); #1;
    i_command_valid = 1'b0;
    check("mid_reset_reg_valid", {31'd0, o_register_valid}, 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    i_rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_rsp_after_reset", {31'd0, o_response_valid}, 32'd0);
    end
    run(1'b0, 8'h38, 16'h0, 16'h0, 0, 32'h0000_BEEF, `RGGEN_OKAY, 0, 1'b0);
`ifdef RGGEN_MASKABLE_ACCESS_TIMEOUT_EN
    run(1'b0, 8'h40, 16'h0, 16'h0, 0, 32'h0, `RGGEN_OKAY, 0, 1'b1);
    run(1'b0, 8'h44, 16'h0, 16'h0, 3, 32'h1111_2222, `RGGEN_OKAY, 0, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("req_queue_empty", req_q.size(), 32'd0);
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
